d16_fetch: RTL and testbench
============================

Name: d16_fetch

Overview:
Instruction fetch stage of the d16 core. It sits directly downstream of the jump unit and consumes that unit's load/mem_addr redirect. It owns the fetch program counter and drives a req/ack instruction-memory port. It presents one fetched instruction at a time, held in a single-entry output register, to the decode stage, with backpressure via stall.

Parameters:
RESET_ADDR, 16'h0000, first fetch address after reset.

Ports:
sys_clk  in  1  core clock; all state updates on rising edge
sys_rst  in  1  synchronous active-high reset
load  in  1  redirect request from jump unit (jump taken)
load_addr  in  16  redirect target (jump unit mem_addr)
stall  in  1  decode cannot accept ir this cycle
imem_req  out  1  instruction memory request
imem_addr  out  16  word address of request
imem_data  in  16  instruction word, valid when imem_ack=1
imem_ack  in  1  memory completes current request; may assert same cycle as imem_req
ir  out  16  fetched instruction
ir_valid  out  1  ir holds an instruction for decode
pc  out  16  word address ir was fetched from

Behaviour:
- Reset (sys_rst=1 at edge):
  - state<=START, fetch_addr<=RESET_ADDR.
  - ir<=0, ir_valid<=0, pc<=0.
  - imem_req=0 while in START.
  - sys_rst overrides every other input, including load and imem_ack.
- Registered state: fetch_addr (16b), ir, pc, ir_valid, state.
- States: START, REQ, FLUSH.
  - START -> REQ unconditionally; imem_req=0.
  - REQ:
    - imem_addr=fetch_addr.
    - imem_req=1 when (!ir_valid || !stall), else 0.
  - FLUSH:
    - imem_req=1 with imem_addr=stale_addr (the address of the request being abandoned).
    - Wait for imem_ack, discard imem_data, then -> REQ.
- Handshake rules:
  - Once imem_req=1 and no ack has arrived, imem_req and imem_addr stay stable until imem_ack.
  - This holds even if stall rises: the stall gate applies only when starting a new request.
  - imem_ack with imem_req=0 is ignored.
- Consume: the output is consumed in a cycle where ir_valid=1 and stall=0.
- Accept (REQ, imem_req=1, imem_ack=1, load=0):
  - ir<=imem_data, pc<=fetch_addr, ir_valid<=1.
  - fetch_addr<=fetch_addr+1, modulo 2^16 (16'hFFFF -> 16'h0000, no flag).
- No accept and consume: ir_valid<=0.
- No accept and no consume: ir, pc, ir_valid hold.
- Throughput: with zero-wait ack, one instruction per cycle. ir_valid/ir appear the cycle after ack.
- Redirect (load=1), highest priority below reset:
  - Always: fetch_addr<=load_addr, ir_valid<=0 (ir/pc contents don't care).
  - Any imem_data acked in the same cycle is discarded.
  - Request outstanding and not acked this cycle: state<=FLUSH, stale_addr latched.
  - Otherwise (no request outstanding, or acked this cycle): state stays/goes REQ.
  - In all cases the next request uses load_addr.
- load while in FLUSH: fetch_addr<=load_addr (last load wins); FLUSH continues until the old ack.
- load with stall=1 simultaneously: redirect still takes effect; ir_valid<=0.
- Redirect latency: load at cycle N.
  - imem_req=1, imem_addr=load_addr at N+1 (N+k+1 if FLUSH ack arrives at N+k).
  - ir_valid=1 earliest at N+2.
- Reset mid-transaction: imem_req drops the next cycle. The memory must tolerate an abandoned request; a late ack is ignored because imem_req=0.

Test Plan:
1. Reset, RESET_ADDR=16'h0000, zero-wait memory returning data=addr^16'hA5A5, stall=0 -> imem_req=0 during START. Addresses 0,1,2,3 on consecutive cycles; ir=A5A5,A5A4,A5A7,A5A6 with pc=0..3, ir_valid continuously 1.
2. Stall=1 for 3 cycles while ir_valid=1 (ir from addr 5) -> ir/pc hold 5 for 3 cycles. No new request starts; fetch of addr 6 resumes the cycle stall falls.
3. Zero-wait stream, load=1 with load_addr=16'h0100 when fetch_addr=16'h0007 -> ack'd data for 7 discarded; ir_valid=0 next cycle. imem_addr=0100 next cycle, ir=mem[0100] with pc=0100 the cycle after.
4. Memory with 3 wait states, load_addr=16'h0040 one cycle after a request to 16'h0010 -> req stays at 0010 until ack, data discarded, ir_valid stays 0. Then req to 0040, and pc=0040 is the first valid instruction.
5. load_addr=16'hFFFE, zero-wait -> pc sequence FFFE, FFFF, 0000, 0001; no glitch at wrap.
6. sys_rst asserted while req outstanding with load=1 and imem_ack=1 -> next cycle imem_req=0, ir_valid=0, pc=0. The first post-reset fetch address is RESET_ADDR, not load_addr.

Source files
------------

// File: rtl/d16_fetch.sv
// d16 instruction fetch stage.
// Owns the fetch program counter, drives a req/ack instruction-memory port and
// hands one instruction at a time to decode via a single-entry output register.
//
// state | meaning
// ------+--------------------------------------------------------------------
// START | first cycle after reset, no memory request
// REQ   | normal fetch from fetch_addr, gated by ir register occupancy/stall
// FLUSH | waiting out an abandoned request at stale_addr, its data discarded
module d16_fetch #(
   parameter logic [15:0] RESET_ADDR = 16'h0000
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        load,
   input  logic [15:0] load_addr,
   input  logic        stall,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic        imem_ack,
   output logic [15:0] ir,
   output logic        ir_valid,
   output logic [15:0] pc
);

   typedef enum logic [1:0] {
      START = 2'd0,
      REQ   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t      state;
   logic [15:0] fetch_addr;
   logic [15:0] stale_addr;
   // a request issued in REQ is still waiting for its ack; keeps imem_req up
   // even if stall rises in the meantime
   logic        pend;
   logic        accept;
   logic        consume;

   // memory port: request gating and address selection per state
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = fetch_addr;
      case (state)
         REQ: begin
            imem_req = pend | ~ir_valid | ~stall;
         end
         FLUSH: begin
            imem_req  = 1'b1;
            imem_addr = stale_addr;
         end
         default: begin
            imem_req = 1'b0;
         end
      endcase
   end

   assign accept  = (state == REQ) && imem_req && imem_ack && !load;
   assign consume = ir_valid && !stall;

   // sequencer, fetch pointer and output register
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= START;
         fetch_addr <= RESET_ADDR;
         stale_addr <= 16'h0000;
         pend       <= 1'b0;
         ir         <= 16'h0000;
         pc         <= 16'h0000;
         ir_valid   <= 1'b0;
      end else begin
         pend <= 1'b0;
         if (load) begin
            fetch_addr <= load_addr;
            ir_valid   <= 1'b0;
            case (state)
               REQ: begin
                  // an unacked request cannot be withdrawn; wait it out in FLUSH
                  if (imem_req && !imem_ack) begin
                     state      <= FLUSH;
                     stale_addr <= fetch_addr;
                  end
               end
               FLUSH: begin
                  if (imem_ack) begin
                     state <= REQ;
                  end
               end
               default: begin
                  state <= REQ;
               end
            endcase
         end else begin
            if (accept) begin
               ir         <= imem_data;
               pc         <= fetch_addr;
               ir_valid   <= 1'b1;
               fetch_addr <= fetch_addr + 16'd1;
            end else if (consume) begin
               ir_valid <= 1'b0;
            end
            case (state)
               START: begin
                  state <= REQ;
               end
               REQ: begin
                  pend <= imem_req && !imem_ack;
               end
               FLUSH: begin
                  if (imem_ack) begin
                     state <= REQ;
                  end
               end
               default: begin
                  state <= START;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_d16_fetch.sv
// Testbench for d16_fetch: vector table, hand-written corner sequences and a
// randomized run, all checked against a transaction-level reference model.
module tb_d16_fetch;

   logic        sys_clk;
   logic        sys_rst;
   logic        load;
   logic [15:0] load_addr;
   logic        stall;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        imem_ack;
   logic [15:0] ir;
   logic        ir_valid;
   logic [15:0] pc;

   d16_fetch #(.RESET_ADDR(16'h0000)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .load      (load),
      .load_addr (load_addr),
      .stall     (stall),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_data (imem_data),
      .imem_ack  (imem_ack),
      .ir        (ir),
      .ir_valid  (ir_valid),
      .pc        (pc)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // memory: mode 0 acks after 'waits' stall cycles, mode 1 acks from ack_raw
   int   waits;
   int   wcnt;
   logic mem_mode;
   logic ack_raw;

   assign imem_ack  = mem_mode ? ack_raw : (imem_req && (wcnt >= waits));
   assign imem_data = imem_addr ^ 16'hA5A5;

   always @(posedge sys_clk) begin
      if (imem_req && !imem_ack) wcnt <= wcnt + 1;
      else                       wcnt <= 0;
   end

   int n_cmp;
   int n_bad;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: tracks the in-flight memory transaction and whether it
   // was abandoned by a redirect, plus the next address to fetch
   logic        m_boot;
   logic        m_infl;
   logic [15:0] m_infl_addr;
   logic        m_dead;
   logic [15:0] m_next;
   logic        m_valid;
   logic [15:0] m_ir;
   logic [15:0] m_pc;

   task automatic model_reset();
      m_boot = 1'b1; m_infl = 1'b0; m_infl_addr = 16'h0; m_dead = 1'b0;
      m_next = 16'h0000; m_valid = 1'b0; m_ir = 16'h0; m_pc = 16'h0;
   endtask

   function automatic logic exp_req();
      return !m_boot && (m_infl || !m_valid || !stall);
   endfunction

   function automatic logic [15:0] exp_addr();
      return m_infl ? m_infl_addr : m_next;
   endfunction

   task automatic model_check();
      logic r;
      r = exp_req();
      chk("imem_req", {15'd0, imem_req}, {15'd0, r});
      if (r) chk("imem_addr", imem_addr, exp_addr());
      chk("ir_valid", {15'd0, ir_valid}, {15'd0, m_valid});
      if (m_valid || m_boot) begin
         chk("ir", ir, m_ir);
         chk("pc", pc, m_pc);
      end
   endtask

   task automatic model_update();
      logic        r, acked, dead_old, infl_old, delivered;
      logic [15:0] a;
      if (sys_rst) begin
         model_reset();
         return;
      end
      r         = exp_req();
      a         = exp_addr();
      acked     = r && imem_ack;
      infl_old  = m_infl;
      dead_old  = m_dead;
      delivered = acked && !(infl_old && dead_old) && !load;
      if (r && !acked) begin
         m_infl      = 1'b1;
         m_infl_addr = a;
         m_dead      = (infl_old ? dead_old : 1'b0) | load;
      end else begin
         m_infl = 1'b0;
         m_dead = 1'b0;
      end
      if (load) begin
         m_next  = load_addr;
         m_valid = 1'b0;
      end else if (delivered) begin
         m_ir    = a ^ 16'hA5A5;
         m_pc    = a;
         m_valid = 1'b1;
         m_next  = a + 16'd1;
      end else if (m_valid && !stall) begin
         m_valid = 1'b0;
      end
      m_boot = 1'b0;
   endtask

   task automatic finish_cycle();
      model_check();
      model_update();
      @(negedge sys_clk);
   endtask

   task automatic tick();
      #1;
      finish_cycle();
   endtask

   typedef struct {
      logic        load;
      logic [15:0] load_addr;
      logic        stall;
      logic        exp_req;
      logic [15:0] exp_addr;
      logic        exp_valid;
      logic [15:0] exp_ir;
      logic [15:0] exp_pc;
      logic        chk_data;
   } vec_t;

   vec_t tbl[14];

   initial begin
      n_cmp = 0; n_bad = 0;
      waits = 0; mem_mode = 1'b0; ack_raw = 1'b0;
      sys_rst = 1'b1; load = 1'b0; load_addr = 16'h0; stall = 1'b0;

      // reset, zero-wait stream, 3-cycle stall at addr 5, redirect at addr 7
      tbl[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1};
      tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1};
      tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b1, 16'hA5A5, 16'h0000, 1'b1};
      tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b1, 16'hA5A4, 16'h0001, 1'b1};
      tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b1, 16'hA5A7, 16'h0002, 1'b1};
      tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b1, 16'hA5A6, 16'h0003, 1'b1};
      tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 1'b1, 16'hA5A1, 16'h0004, 1'b1};
      tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0006, 1'b1, 16'hA5A0, 16'h0005, 1'b1};
      tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0006, 1'b1, 16'hA5A0, 16'h0005, 1'b1};
      tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0006, 1'b1, 16'hA5A0, 16'h0005, 1'b1};
      tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0006, 1'b1, 16'hA5A0, 16'h0005, 1'b1};
      tbl[11] = '{1'b1, 16'h0100, 1'b0, 1'b1, 16'h0007, 1'b1, 16'hA5A3, 16'h0006, 1'b1};
      tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000, 1'b0};
      tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0101, 1'b1, 16'hA4A5, 16'h0100, 1'b1};

      model_reset();
      @(posedge sys_clk);
      @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         load = tbl[i].load; load_addr = tbl[i].load_addr; stall = tbl[i].stall;
         #1;
         chk($sformatf("tbl%0d req", i), {15'd0, imem_req}, {15'd0, tbl[i].exp_req});
         if (tbl[i].exp_req) chk($sformatf("tbl%0d addr", i), imem_addr, tbl[i].exp_addr);
         chk($sformatf("tbl%0d valid", i), {15'd0, ir_valid}, {15'd0, tbl[i].exp_valid});
         if (tbl[i].chk_data) begin
            chk($sformatf("tbl%0d ir", i), ir, tbl[i].exp_ir);
            chk($sformatf("tbl%0d pc", i), pc, tbl[i].exp_pc);
         end
         finish_cycle();
      end

      // redirect during a 3-wait-state request: old request must complete first
      load = 1'b1; load_addr = 16'h0010; stall = 1'b0;
      tick();
      load = 1'b0; waits = 3;
      #1; chk("ws req 0010", imem_addr, 16'h0010); finish_cycle();
      load = 1'b1; load_addr = 16'h0040;
      #1; chk("ws hold 0010 a", imem_addr, 16'h0010); finish_cycle();
      load = 1'b0;
      #1; chk("ws hold 0010 b", imem_addr, 16'h0010);
      chk("ws valid b", {15'd0, ir_valid}, 16'h0000); finish_cycle();
      #1; chk("ws hold 0010 c", imem_addr, 16'h0010);
      chk("ws req c", {15'd0, imem_req}, 16'h0001); finish_cycle();
      #1; chk("ws req 0040", imem_addr, 16'h0040);
      chk("ws valid flush", {15'd0, ir_valid}, 16'h0000); finish_cycle();
      tick(); tick(); tick();
      #1; chk("ws pc 0040", pc, 16'h0040);
      chk("ws valid 0040", {15'd0, ir_valid}, 16'h0001); finish_cycle();

      // address wrap
      waits = 0; load = 1'b1; load_addr = 16'hFFFE;
      tick();
      load = 1'b0;
      #1; chk("wrap req FFFE", imem_addr, 16'hFFFE); finish_cycle();
      for (int k = 0; k < 4; k++) begin
         logic [15:0] e;
         e = 16'hFFFE + 16'(k);
         #1;
         chk($sformatf("wrap pc%0d", k), pc, e);
         chk($sformatf("wrap valid%0d", k), {15'd0, ir_valid}, 16'h0001);
         finish_cycle();
      end

      // reset while a request is outstanding, with load and ack also asserted
      waits = 3;
      tick();
      sys_rst = 1'b1; load = 1'b1; load_addr = 16'h1234; mem_mode = 1'b1; ack_raw = 1'b1;
      tick();
      sys_rst = 1'b0; load = 1'b0; mem_mode = 1'b0; ack_raw = 1'b0;
      #1;
      chk("rst req", {15'd0, imem_req}, 16'h0000);
      chk("rst valid", {15'd0, ir_valid}, 16'h0000);
      chk("rst pc", pc, 16'h0000);
      finish_cycle();
      #1; chk("rst first addr", imem_addr, 16'h0000);
      chk("rst first req", {15'd0, imem_req}, 16'h0001); finish_cycle();

      // randomized traffic
      for (int blk = 0; blk < 15; blk++) begin
         mem_mode = blk[0];
         waits    = int'($urandom_range(0, 3));
         for (int c = 0; c < 200; c++) begin
            sys_rst   = ($urandom_range(0, 199) == 0);
            load      = ($urandom_range(0, 7) == 0);
            load_addr = 16'($urandom);
            stall     = ($urandom_range(0, 2) == 0);
            ack_raw   = ($urandom_range(0, 1) == 0);
            tick();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
